// File: rtl/data_mem_pkg.sv
// Shared widths, default depth and byte-address to word-index mapping
// for the CPU data memory.
package data_mem_pkg;

    localparam int WORD_W          = 32;
    localparam int BYTE_W          = 8;
    localparam int LANES           = WORD_W / BYTE_W;
    localparam int DEPTH_BYTES_DEF = 256;

    // Low two bits select a byte within the word and are dropped; bits at or
    // above log2(depth) are masked off so the address wraps.
    function automatic int unsigned word_index(input logic [31:0] byte_addr,
                                               input int unsigned depth_bytes);
        return (byte_addr & (depth_bytes - 32'd1)) >> 2;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Load/store port between the execute stage and the data memory.
interface data_mem_if
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = 32
);

    logic [WORD_W-1:0] Din;
    logic [WORD_W-1:0] Dout;
    logic [ADDR_W-1:0] addr;
    logic              memWrt;

    modport master (output Din, output addr, output memWrt, input Dout);
    modport slave  (input Din, input addr, input memWrt, output Dout);

endinterface

// File: rtl/data_mem_lane.sv
// One byte lane of the data memory: synchronous clear and write,
// combinational read.
module data_mem_lane
    import data_mem_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout
);

    logic [BYTE_W-1:0] mem [ENTRIES];

    // Clear wins over a write issued on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= din;
        end
    end

    assign dout = mem[idx];

endmodule

// File: rtl/data_mem.sv
// Word-wide, byte-addressed, big-endian data memory built from four byte
// lanes; lane 0 holds the byte at the lowest address (Din[31:24]).
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = DEPTH_BYTES_DEF,
    parameter int ADDR_W      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    data_mem_if.slave  bus
);

    localparam int ENTRIES = DEPTH_BYTES / LANES;
    localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  idx;
    logic [BYTE_W-1:0] lane_dout [LANES];

    assign addr = bus.addr;
    assign idx  = IDX_W'(word_index(32'(addr), DEPTH_BYTES));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        data_mem_lane #(
            .ENTRIES (ENTRIES),
            .IDX_W   (IDX_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (bus.memWrt),
            .idx   (idx),
            .din   (bus.Din[WORD_W-1-BYTE_W*l -: BYTE_W]),
            .dout  (lane_dout[l])
        );
    end

    assign bus.Dout = {lane_dout[0], lane_dout[1], lane_dout[2], lane_dout[3]};

endmodule

// File: tb/tb_data_mem.sv
// Directed and randomized checks of data_mem against a flat byte-array model.
module tb_data_mem;

    localparam int DEPTH = 256;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    byte unsigned model_mem [DEPTH];

    data_mem_if #(.ADDR_W(32)) bus ();

    data_mem #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned base_of(input logic [31:0] a);
        return (a % DEPTH) / 4 * 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned b;
        b = base_of(a);
        return {model_mem[b], model_mem[b+1], model_mem[b+2], model_mem[b+3]};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        int unsigned b;
        b = base_of(a);
        model_mem[b]   = d[31:24];
        model_mem[b+1] = d[23:16];
        model_mem[b+2] = d[15:8];
        model_mem[b+3] = d[7:0];
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
        @(negedge clk);
        bus.addr   = a;
        bus.Din    = d;
        bus.memWrt = we;
    endtask

    // Advance one rising edge, applying the edge's effect to the model.
    task automatic tick();
        @(posedge clk);
        if (rst_n === 1'b0) model_clear();
        else if (bus.memWrt === 1'b1) model_write(bus.addr, bus.Din);
        #1;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a);
        @(negedge clk);
        bus.addr   = a;
        bus.memWrt = 1'b0;
        #1;
        chk(tag, bus.Dout, model_read(a));
    endtask

    initial begin
        logic [31:0] pat [4];
        logic [31:0] a;
        logic [31:0] d;
        logic        we;

        checks = 0;
        errors = 0;
        pat[0] = 32'h0000_1248;
        pat[1] = 32'h0000_2481;
        pat[2] = 32'h0000_4812;
        pat[3] = 32'h0000_8124;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'hA5;

        rst_n      = 1'b0;
        bus.addr   = '0;
        bus.Din    = '0;
        bus.memWrt = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;

        read_chk("reset_a00", 32'h00);
        chk("reset_a00_const", bus.Dout, 32'h0);
        read_chk("reset_a04", 32'h04);
        read_chk("reset_afc", 32'hFC);

        for (int i = 0; i < 8; i++) begin
            drive(32'h0, pat[i % 4], (i % 2) == 0);
            tick();
            chk($sformatf("toggle_%0d", i), bus.Dout, model_read(32'h0));
        end

        drive(32'h8, 32'h1122_3344, 1'b1);
        tick();
        read_chk("be_word", 32'h8);
        chk("be_word_const", bus.Dout, 32'h1122_3344);
        chk("be_byte8", {24'h0, bus.Dout[31:24]}, {24'h0, model_mem[8]});
        chk("be_byte11", {24'h0, bus.Dout[7:0]}, 32'h44);

        drive(32'h13, 32'hDEAD_BEEF, 1'b1);
        tick();
        read_chk("align_a10", 32'h10);
        chk("align_const", bus.Dout, 32'hDEAD_BEEF);

        drive(32'h104, 32'hCAFE_F00D, 1'b1);
        tick();
        read_chk("wrap_a04", 32'h04);
        chk("wrap_const", bus.Dout, 32'hCAFE_F00D);

        drive(32'h30, 32'hAAAA_AAAA, 1'b1);
        tick();
        drive(32'h30, 32'h5555_5555, 1'b1);
        #1;
        chk("rdw_before", bus.Dout, 32'hAAAA_AAAA);
        tick();
        chk("rdw_after", bus.Dout, 32'h5555_5555);
        read_chk("rdw_other_a08", 32'h08);
        read_chk("rdw_other_a10", 32'h10);
        read_chk("rdw_other_a2c", 32'h2C);

        for (int i = 0; i < 60; i++) begin
            a  = $urandom;
            d  = $urandom;
            we = 1'($urandom_range(0, 1));
            drive(a, d, we);
            tick();
            chk($sformatf("rnd_wr_%0d", i), bus.Dout, model_read(a));
            read_chk($sformatf("rnd_rd_%0d", i), $urandom);
        end

        drive(32'h20, 32'hFFFF_FFFF, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("rstpri_a20", bus.Dout, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        read_chk("rstpri_a00", 32'h00);
        read_chk("rstpri_a08", 32'h08);
        read_chk("rstpri_a10", 32'h10);
        chk("rstpri_a10_const", bus.Dout, 32'h0);
        read_chk("rstpri_a30", 32'h30);
        read_chk("rstpri_afc", 32'hFC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
